iiitb_cps_gate_arbiter: RTL
===========================

Name: iiitb_cps_gate_arbiter

Overview:
Controller/arbiter for one shared parking barrier gate serving two entrance lanes and one exit lane. Grants the gate to one requester at a time and holds it open until the vehicle passes or a timeout expires. Maintains lot occupancy against a fixed capacity. Sits between the lane sensors and the parking access logic (password check, LEDs, 7-seg display), which consumes count/full/empty.

Parameters:
CAPACITY, 8, number of parking slots; CNT_W must be able to represent it.
GATE_CYCLES, 16, maximum cycles the gate stays open per grant (>=2).
CNT_W, 4, occupancy counter width.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_ent  input  2  entrance lane requests, one bit per lane, level-sensitive
req_exit  input  1  exit lane request, level-sensitive
pass  input  1  vehicle-crossed-barrier sensor, sampled only in OPEN
grant_ent  output  2  one-hot entrance grant, registered
grant_exit  output  1  exit grant, registered
gate_open  output  1  barrier open command, registered
count  output  CNT_W  current occupancy
full  output  1  count == CAPACITY
empty  output  1  count == 0
busy  output  1  state != IDLE

Behaviour:
- One clock (clk), asynchronous active-low reset (reset_n). All state is cleared immediately on reset_n low.
- Reset values:
  - grant_ent=00, grant_exit=0, gate_open=0, busy=0.
  - count=0, so empty=1 and full=0.
  - Round-robin pointer=0 (lane 0 favoured), timer=0, state=IDLE.
- Reset asserted mid-transaction: the transaction is abandoned, count is cleared, and the gate closes immediately.
- FSM has three states: IDLE, OPEN, CLOSE.
- IDLE: requests are sampled each cycle; the first match in this order wins:
  - req_exit=1 and count>0 → OPEN with grant_exit=1.
  - Any req_ent bit=1 and count<CAPACITY → OPEN, granting the round-robin winner.
  - Otherwise remain in IDLE.
- Exit has strict priority over entrances when requests arrive in the same cycle.
- Round-robin rule:
  - With both req_ent bits high, the lane not granted most recently wins.
  - The pointer updates on the grant edge, and only for entrance grants.
  - With one bit high, that lane wins regardless of the pointer.
- Latency: a valid request in IDLE at cycle t gives grant and gate_open high from cycle t+1.
- OPEN:
  - Grant and gate_open are held; the timer loads GATE_CYCLES-1 on entry and decrements each cycle.
  - pass=1 → CLOSE next cycle, transaction counted.
  - Timer==0 with pass=0 → CLOSE next cycle, transaction not counted (timeout).
  - pass=1 in the same cycle as timer==0 counts as a pass.
  - Request bits are ignored in OPEN; dropping req does not end the grant.
- CLOSE: lasts exactly 1 cycle.
  - grant_ent, grant_exit and gate_open are 0; busy=1.
  - count has already been updated on the OPEN→CLOSE edge: +1 for a counted entrance, −1 for a counted exit.
  - Next state is IDLE.
- Minimum transaction length: 3 cycles (OPEN, CLOSE, IDLE) before the next grant is possible.
- Maximum gate_open high time: exactly GATE_CYCLES cycles.
- Boundaries:
  - While full=1, entrance requests are ignored; an exit is still served.
  - While empty=1, exit requests are ignored.
  - count never wraps.
  - pass outside OPEN is ignored.
- full and empty are decoded directly from the count register, with no extra latency.

Optional Feature:
Macro: CPS_TIMEOUT_CNT_EN.
- Defined: adds output port timeout_cnt [7:0].
  - Reset to 0.
  - Increments on each OPEN→CLOSE transition caused by a timeout.
  - Saturates at 255.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold reset_n=0 for 5 cycles with req_ent=11 → all grants=0, gate_open=0, count=0, empty=1, full=0, busy=0. Release reset → grant_ent=01 one cycle after the first IDLE sample.
2. Single entrance: req_ent=01, pulse pass in the 3rd OPEN cycle → grant_ent=01 and gate_open high for 3 cycles, one CLOSE cycle with outputs low, then count=1 and empty=0.
3. Round robin: hold req_ent=11 and pulse pass in each OPEN → grant_ent sequence 01, 10, 01, 10; count reaches 4.
4. Exit priority: preload count=2, then assert req_exit=1 and req_ent=01 in the same cycle → grant_exit first, count=1 after CLOSE, then grant_ent=01 served, count=2.
5. Full: fill to count=8 → full=1; req_ent=11 then leaves busy=0 with no grant. Serve one exit with pass → count=7, full=0, and the next entrance is granted.
6. Timeout: req_ent=10 with pass never asserted → gate_open high for exactly 16 cycles, count unchanged; timeout_cnt=1 when CPS_TIMEOUT_CNT_EN is defined.

Source files
------------

// File: rtl/iiitb_cps_gate_arbiter.sv
// Shared parking barrier gate arbiter: two entrance lanes and one exit lane.
// Grants the gate to one requester at a time, holds it open until the vehicle
// passes or the open window expires, and tracks lot occupancy against CAPACITY.
// Optional build macro CPS_TIMEOUT_CNT_EN adds an 8-bit saturating count of
// grants that ended by timeout.
module iiitb_cps_gate_arbiter #(
    parameter int unsigned CAPACITY    = 8,
    parameter int unsigned GATE_CYCLES = 16,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_ent,
    input  logic             req_exit,
    input  logic             pass,
    output logic [1:0]       grant_ent,
    output logic             grant_exit,
    output logic             gate_open,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             busy
`ifdef CPS_TIMEOUT_CNT_EN
    ,
    output logic [7:0]       timeout_cnt
`endif
);

    localparam int unsigned TimerW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CapVal    = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StClose
    } state_e;

    state_e            state_q;
    logic              rr_ptr_q;   // entrance lane favoured when both request
    logic [TimerW-1:0] timer_q;
    logic [CNT_W-1:0]  count_q;

    logic can_exit;
    logic can_ent;
    logic ent_pick;                // 1 selects entrance lane 1

    // Request qualification and round-robin pick, all from registered state.
    always_comb begin
        can_exit = req_exit && (count_q != '0);
        can_ent  = (|req_ent) && (count_q < CapVal);
        ent_pick = (&req_ent) ? rr_ptr_q : req_ent[1];
    end

    // Gate control FSM with registered grants, timer and occupancy counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= 1'b0;
            timer_q    <= '0;
            count_q    <= '0;
            grant_ent  <= 2'b00;
            grant_exit <= 1'b0;
            gate_open  <= 1'b0;
`ifdef CPS_TIMEOUT_CNT_EN
            timeout_cnt <= 8'd0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (can_exit) begin
                        state_q    <= StOpen;
                        grant_exit <= 1'b1;
                        gate_open  <= 1'b1;
                        timer_q    <= TimerLoad;
                    end else if (can_ent) begin
                        state_q   <= StOpen;
                        grant_ent <= {ent_pick, ~ent_pick};
                        rr_ptr_q  <= ~ent_pick;
                        gate_open <= 1'b1;
                        timer_q   <= TimerLoad;
                    end
                end
                StOpen: begin
                    if (pass || (timer_q == '0)) begin
                        state_q    <= StClose;
                        grant_ent  <= 2'b00;
                        grant_exit <= 1'b0;
                        gate_open  <= 1'b0;
                        if (pass) begin
                            // Guards keep the counter from wrapping.
                            if (grant_exit && (count_q != '0)) begin
                                count_q <= count_q - CNT_W'(1);
                            end else if ((|grant_ent) && (count_q < CapVal)) begin
                                count_q <= count_q + CNT_W'(1);
                            end
                        end
`ifdef CPS_TIMEOUT_CNT_EN
                        else if (timeout_cnt != 8'hff) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
`endif
                    end else begin
                        timer_q <= timer_q - TimerW'(1);
                    end
                end
                StClose: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Status decoded straight from the registers.
    always_comb begin
        count = count_q;
        full  = (count_q == CapVal);
        empty = (count_q == '0);
        busy  = (state_q != StIdle);
    end

endmodule
